// File: rtl/tree_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tree_sum_accumulator
//
// Placed directly after the root node of a pipelined adder tree. Delays the
// sample tag to match the tree latency, then adds up a programmable number of
// consecutive root sums into one wide frame total. Each finished frame
// produces a one-cycle result pulse with a sticky overflow flag. The tree
// cannot stall, so there is no backpressure.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort: flushes the tag pipe and the frame state
//   in_valid   sample tag, asserted in the same cycle data enters the tree
//   len        samples per frame (0 is treated as 1), sampled at frame start
//   tree_sum   root sum from the adder tree
//   out_valid  one-cycle pulse, frame result valid
//   out_sum    frame total, held until the next completion
//   out_ovf    frame overflowed, qualified by out_valid
//   busy       frame in progress (ACCUM state)
//   count      aligned samples accepted in the current frame
// -----------------------------------------------------------------------------
module tree_sum_accumulator #(
   parameter int IN_BITS      = 17,
   parameter int ACC_BITS     = 24,
   parameter int SIGN_EXT     = 1,
   parameter int TREE_LATENCY = 2,
   parameter int LEN_BITS     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [LEN_BITS-1:0] len,
   input  logic [IN_BITS-1:0]  tree_sum,
   output logic                out_valid,
   output logic [ACC_BITS-1:0] out_sum,
   output logic                out_ovf,
   output logic                busy,
   output logic [LEN_BITS-1:0] count
);

   localparam logic IDLE  = 1'b0;
   localparam logic ACCUM = 1'b1;

   localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

   logic v_al;

   // ---------------------------------------------------------------------
   // Tag alignment: in_valid delayed by the tree latency.
   // ---------------------------------------------------------------------
   generate
      if (TREE_LATENCY == 0) begin : g_no_pipe
         assign v_al = in_valid;
      end else begin : g_pipe
         logic [TREE_LATENCY-1:0] tag_pipe_reg;
         genvar gi;
         for (gi = 0; gi < TREE_LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n)     tag_pipe_reg[gi] <= 1'b0;
                  else if (clear) tag_pipe_reg[gi] <= 1'b0;
                  else            tag_pipe_reg[gi] <= in_valid;
               end
            end else begin : g_next
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n)     tag_pipe_reg[gi] <= 1'b0;
                  else if (clear) tag_pipe_reg[gi] <= 1'b0;
                  else            tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
               end
            end
         end
         assign v_al = tag_pipe_reg[TREE_LATENCY-1];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Extension of the root sum to accumulator width.
   // ---------------------------------------------------------------------
   logic [ACC_BITS-1:0] ext;

   generate
      if (ACC_BITS == IN_BITS) begin : g_ext_none
         assign ext = tree_sum;
      end else if (SIGN_EXT != 0) begin : g_ext_sign
         assign ext = {{(ACC_BITS-IN_BITS){tree_sum[IN_BITS-1]}}, tree_sum};
      end else begin : g_ext_zero
         assign ext = {{(ACC_BITS-IN_BITS){1'b0}}, tree_sum};
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                state_reg,     state_next;
   logic [ACC_BITS-1:0] acc_reg,       acc_next;
   logic [LEN_BITS-1:0] count_reg,     count_next;
   logic [LEN_BITS-1:0] len_reg,       len_next;
   logic                sticky_reg,    sticky_next;
   logic                out_valid_reg, out_valid_next;
   logic [ACC_BITS-1:0] out_sum_reg,   out_sum_next;
   logic                out_ovf_reg,   out_ovf_next;

   // Adder with one extra bit so the unsigned carry is visible.
   logic [ACC_BITS:0]   sum_full;
   logic [ACC_BITS-1:0] sum;
   logic                ovf_signed;
   logic                add_ovf;
   logic [LEN_BITS-1:0] len_eff;
   logic [LEN_BITS-1:0] count_inc;

   assign sum_full   = {1'b0, acc_reg} + {1'b0, ext};
   assign sum        = sum_full[ACC_BITS-1:0];
   // Signed overflow: equal operand signs, result sign differs.
   assign ovf_signed = (acc_reg[ACC_BITS-1] == ext[ACC_BITS-1]) &&
                       (sum[ACC_BITS-1] != acc_reg[ACC_BITS-1]);
   assign add_ovf    = (SIGN_EXT != 0) ? ovf_signed : sum_full[ACC_BITS];
   assign len_eff    = (len == '0) ? LEN_ONE : len;
   assign count_inc  = count_reg + LEN_ONE;

   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      count_next     = count_reg;
      len_next       = len_reg;
      sticky_next    = sticky_reg;
      out_valid_next = 1'b0;
      out_sum_next   = out_sum_reg;
      out_ovf_next   = 1'b0;

      if (clear) begin
         // Abort wins over any sample or completion in the same cycle;
         // the last published total stays visible.
         state_next  = IDLE;
         acc_next    = '0;
         count_next  = '0;
         sticky_next = 1'b0;
      end else if (v_al) begin
         if (state_reg == IDLE) begin
            // First sample of a frame: load, never overflows.
            len_next    = len_eff;
            acc_next    = ext;
            sticky_next = 1'b0;
            if (len_eff == LEN_ONE) begin
               out_valid_next = 1'b1;
               out_sum_next   = ext;
               count_next     = '0;
            end else begin
               count_next = LEN_ONE;
               state_next = ACCUM;
            end
         end else begin
            acc_next    = sum;
            sticky_next = sticky_reg | add_ovf;
            if (count_inc == len_reg) begin
               out_valid_next = 1'b1;
               out_sum_next   = sum;
               out_ovf_next   = sticky_reg | add_ovf;
               count_next     = '0;
               state_next     = IDLE;
            end else begin
               count_next = count_inc;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         count_reg     <= '0;
         len_reg       <= '0;
         sticky_reg    <= 1'b0;
         out_valid_reg <= 1'b0;
         out_sum_reg   <= '0;
         out_ovf_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         count_reg     <= count_next;
         len_reg       <= len_next;
         sticky_reg    <= sticky_next;
         out_valid_reg <= out_valid_next;
         out_sum_reg   <= out_sum_next;
         out_ovf_reg   <= out_ovf_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_sum   = out_sum_reg;
   assign out_ovf   = out_ovf_reg;
   assign busy      = (state_reg == ACCUM);
   assign count     = count_reg;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_tree_sum_accumulator
//
// Directed bench for tree_sum_accumulator. Two instances share the stimulus:
// the default configuration (24-bit accumulator) and a 17-bit accumulator
// used for the signed overflow frames. Each sequence is a per-cycle table of
// tags, clears and tree-aligned sums with hand-computed expected outputs.
// -----------------------------------------------------------------------------
module tb_tree_sum_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic [7:0]  len;
   logic [16:0] tree_sum;

   logic        out_valid;
   logic [23:0] out_sum;
   logic        out_ovf;
   logic        busy;
   logic [7:0]  count;

   logic        out_valid17;
   logic [16:0] out_sum17;
   logic        out_ovf17;
   logic        busy17;
   logic [7:0]  count17;

   int total;
   int bad;

   // Per-cycle tables for the current sequence.
   logic [16:0] sum_tbl     [16];
   logic [31:0] exp_sum_tbl [16];
   logic [7:0]  exp_cnt_tbl [16];
   logic [15:0] exp_ovf_mask;

   tree_sum_accumulator #(
      .IN_BITS(17), .ACC_BITS(24), .SIGN_EXT(1), .TREE_LATENCY(2), .LEN_BITS(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .len(len), .tree_sum(tree_sum),
      .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf),
      .busy(busy), .count(count)
   );

   tree_sum_accumulator #(
      .IN_BITS(17), .ACC_BITS(17), .SIGN_EXT(1), .TREE_LATENCY(2), .LEN_BITS(8)
   ) dut17 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
      .len(len), .tree_sum(tree_sum),
      .out_valid(out_valid17), .out_sum(out_sum17), .out_ovf(out_ovf17),
      .busy(busy17), .count(count17)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clr_tbls();
      for (int i = 0; i < 16; i++) begin
         sum_tbl[i]     = '0;
         exp_sum_tbl[i] = '0;
         exp_cnt_tbl[i] = '0;
      end
      exp_ovf_mask = '0;
   endtask

   // Runs ncyc cycles. Inputs are driven 1 time unit after the rising edge,
   // outputs are sampled on the falling edge of the same cycle.
   task automatic run_seq(input string name, input int ncyc,
                          input logic [15:0] tags, input logic [15:0] clrs,
                          input logic [15:0] ov_exp, input logic [15:0] busy_exp,
                          input logic [7:0] ln, input bit sel17);
      logic        g_ov;
      logic        g_busy;
      logic        g_ovf;
      logic [31:0] g_sum;
      logic [7:0]  g_cnt;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk);
         #1;
         in_valid = tags[c];
         clear    = clrs[c];
         tree_sum = sum_tbl[c];
         len      = ln;
         @(negedge clk);
         if (sel17) begin
            g_ov = out_valid17; g_busy = busy17; g_ovf = out_ovf17;
            g_sum = {15'd0, out_sum17}; g_cnt = count17;
         end else begin
            g_ov = out_valid; g_busy = busy; g_ovf = out_ovf;
            g_sum = {8'd0, out_sum}; g_cnt = count;
         end
         chk($sformatf("%s c%0d out_valid", name, c), {31'd0, g_ov}, {31'd0, ov_exp[c]});
         chk($sformatf("%s c%0d busy", name, c), {31'd0, g_busy}, {31'd0, busy_exp[c]});
         chk($sformatf("%s c%0d count", name, c), {24'd0, g_cnt}, {24'd0, exp_cnt_tbl[c]});
         if (ov_exp[c]) begin
            chk($sformatf("%s c%0d out_sum", name, c), g_sum, exp_sum_tbl[c]);
            chk($sformatf("%s c%0d out_ovf", name, c), {31'd0, g_ovf},
                {31'd0, exp_ovf_mask[c]});
         end
         if (g_ov)
            $display("%s c%0d result out_sum=%0h out_ovf=%0d", name, c, g_sum, g_ovf);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clear    = 1'b0;
      tree_sum = '0;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      len      = 8'd0;
      tree_sum = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_sum",   {8'd0, out_sum},    32'd0);
      chk("reset out_ovf",   {31'd0, out_ovf},   32'd0);
      chk("reset busy",      {31'd0, busy},      32'd0);
      chk("reset count",     {24'd0, count},     32'd0);
      chk("reset17 out_sum", {15'd0, out_sum17}, 32'd0);
      rst_n = 1'b1;

      // Four contiguous samples 10,-3,7,1.
      clr_tbls();
      sum_tbl[2] = 17'd10; sum_tbl[3] = 17'h1FFFD; sum_tbl[4] = 17'd7; sum_tbl[5] = 17'd1;
      exp_cnt_tbl[3] = 8'd1; exp_cnt_tbl[4] = 8'd2; exp_cnt_tbl[5] = 8'd3;
      exp_sum_tbl[6] = 32'd15;
      run_seq("len4", 9, 16'h000F, 16'h0000, 16'h0040, 16'h0038, 8'd4, 1'b0);

      // Three samples with a gap.
      clr_tbls();
      sum_tbl[2] = 17'd5; sum_tbl[6] = 17'd5; sum_tbl[7] = 17'd5;
      exp_cnt_tbl[3] = 8'd1; exp_cnt_tbl[4] = 8'd1; exp_cnt_tbl[5] = 8'd1;
      exp_cnt_tbl[6] = 8'd1; exp_cnt_tbl[7] = 8'd2;
      exp_sum_tbl[8] = 32'd15;
      run_seq("gap", 10, 16'h0031, 16'h0000, 16'h0100, 16'h00F8, 8'd3, 1'b0);

      // One-sample frames, len=1 then len=0.
      clr_tbls();
      sum_tbl[2] = 17'd1; sum_tbl[3] = 17'd2; sum_tbl[4] = 17'd3;
      exp_sum_tbl[3] = 32'd1; exp_sum_tbl[4] = 32'd2; exp_sum_tbl[5] = 32'd3;
      run_seq("len1", 7, 16'h0007, 16'h0000, 16'h0038, 16'h0000, 8'd1, 1'b0);
      run_seq("len0", 7, 16'h0007, 16'h0000, 16'h0038, 16'h0000, 8'd0, 1'b0);

      // 17-bit accumulator: 65535+1 overflows, then back-to-back 2+2 does not.
      clr_tbls();
      sum_tbl[2] = 17'h0FFFF; sum_tbl[3] = 17'd1; sum_tbl[4] = 17'd2; sum_tbl[5] = 17'd2;
      exp_cnt_tbl[3] = 8'd1; exp_cnt_tbl[5] = 8'd1;
      exp_sum_tbl[4] = 32'h10000; exp_sum_tbl[6] = 32'd4;
      exp_ovf_mask[4] = 1'b1;
      run_seq("ovf17", 8, 16'h000F, 16'h0000, 16'h0050, 16'h0028, 8'd2, 1'b1);

      // Clear after two samples; the in-flight tag is flushed, fresh frame follows.
      clr_tbls();
      sum_tbl[2] = 17'd9; sum_tbl[3] = 17'd9; sum_tbl[4] = 17'd9;
      sum_tbl[8] = 17'd1; sum_tbl[9] = 17'd1; sum_tbl[10] = 17'd1; sum_tbl[11] = 17'd1;
      exp_cnt_tbl[3] = 8'd1; exp_cnt_tbl[4] = 8'd2;
      exp_cnt_tbl[9] = 8'd1; exp_cnt_tbl[10] = 8'd2; exp_cnt_tbl[11] = 8'd3;
      exp_sum_tbl[12] = 32'd4;
      run_seq("clear", 14, 16'h03CF, 16'h0010, 16'h1000, 16'h0E18, 8'd4, 1'b0);

      // Reset mid-frame with count=2.
      clr_tbls();
      sum_tbl[2] = 17'd3; sum_tbl[3] = 17'd3;
      exp_cnt_tbl[3] = 8'd1; exp_cnt_tbl[4] = 8'd2;
      run_seq("prerst", 5, 16'h0003, 16'h0000, 16'h0000, 16'h0018, 8'd4, 1'b0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst out_sum",   {8'd0, out_sum},    32'd0);
      chk("midrst out_ovf",   {31'd0, out_ovf},   32'd0);
      chk("midrst busy",      {31'd0, busy},      32'd0);
      chk("midrst count",     {24'd0, count},     32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      clr_tbls();
      sum_tbl[2] = 17'd3; sum_tbl[3] = 17'd4;
      exp_cnt_tbl[3] = 8'd1;
      exp_sum_tbl[4] = 32'd7;
      run_seq("postrst", 6, 16'h0003, 16'h0000, 16'h0010, 16'h0008, 8'd2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
Sits directly downstream of the root adder_tree_node of a pipelined adder tree. Re-aligns a sample-valid tag, issued at the tree input, with the tree's fixed pipeline latency. Accumulates a programmable number of consecutive root sums into one wide frame total. Emits a one-cycle-valid result with a sticky overflow flag. The tree cannot stall, so the block is stream-only, with no backpressure.

Parameters:
IN_BITS, 17, width of the tree root sum
ACC_BITS, 24, accumulator and result width (must be >= IN_BITS)
SIGN_EXT, 1, 1 = tree_sum is two's-complement and is sign-extended; 0 = unsigned and zero-extended
TREE_LATENCY, 2, clock cycles from the tree input to tree_sum (0..16)
LEN_BITS, 8, width of the frame-length input

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort: flushes the tag pipe and the accumulator
in_valid  in  1  sample tag, asserted in the same cycle data enters the tree
len  in  LEN_BITS  samples per frame, sampled at frame start
tree_sum  in  IN_BITS  root sum from the adder tree
out_valid  out  1  one-cycle pulse, frame result valid
out_sum  out  ACC_BITS  frame total
out_ovf  out  1  frame overflowed; qualified by out_valid
busy  out  1  frame in progress (at least one aligned sample accepted, frame not yet complete)
count  out  LEN_BITS  aligned samples accepted in the current frame

Behaviour:
- Reset (rst_n=0, asynchronous):
  - tag pipe, acc, count, out_sum and the internal sticky overflow all cleared to 0.
  - out_valid=0, out_ovf=0, busy=0.
  - Applies immediately and mid-frame; the partial frame is lost and no output is produced.
- Tag alignment:
  - in_valid passes through a TREE_LATENCY-deep shift register; its output is v_al.
  - TREE_LATENCY=0: v_al=in_valid, combinational.
  - tree_sum is consumed only in cycles where v_al=1.
- Extension: ext = tree_sum sign-extended (SIGN_EXT=1) or zero-extended (SIGN_EXT=0) to ACC_BITS.
- State machine, two states: IDLE and ACCUM.
  - IDLE, v_al=1:
    - latch frame length L = (len==0) ? 1 : len. The len value is taken in the cycle v_al rises, not the tag cycle.
    - acc<=ext; count<=1; clear the sticky overflow.
    - If L==1: complete immediately (see Completion) and stay in IDLE. Otherwise go to ACCUM.
  - ACCUM, v_al=1:
    - acc<=acc+ext, wrapping modulo 2^ACC_BITS; count<=count+1.
    - If count+1==L: complete and go to IDLE.
  - ACCUM, v_al=0: hold all state. Gaps between samples are permitted and unlimited.
- Completion (registered outputs):
  - next cycle: out_valid=1 for exactly one cycle.
  - out_sum = final acc value, including the last sample.
  - out_ovf = sticky OR (last add overflowed).
  - count returns to 0.
  - out_sum holds its value until the next completion. out_ovf is meaningful only while out_valid=1.
- Back-to-back frames: a sample with v_al=1 in the cycle after completion starts a new frame with no bubble. A frame may also complete every cycle when L==1.
- Latency: out_valid rises TREE_LATENCY+1 cycles after the in_valid tag of the frame's last sample.
- Overflow detection:
  - SIGN_EXT=1: the operands have equal signs and the result sign differs.
  - SIGN_EXT=0: carry out of bit ACC_BITS-1.
  - The first sample of a frame never overflows.
- clear=1:
  - next cycle: tag pipe zeroed, state IDLE, count=0, acc=0, sticky overflow=0, out_valid=0.
  - out_sum is retained.
  - clear wins over a simultaneous v_al or completion: that sample is dropped and no out_valid is produced.
  - Tags entering after clear deasserts are processed normally.
- busy=1 exactly while in ACCUM.
- len is ignored outside frame start; changing it mid-frame has no effect.

Test Plan:
- LEN_BITS default, TREE_LATENCY=2, signed; len=4; tags in cycles 0..3 with tree_sum aligned 10,-3,7,1 -> out_valid only in cycle 6, out_sum=15, out_ovf=0, busy 1 in cycles 3..5.
- len=3; tags in cycles 0,4,5 with sum=5 each -> out_valid in cycle 8, out_sum=15; busy and count=1 held through the gap.
- len=1 with continuous tags, sums 1,2,3 -> out_valid on 3 consecutive cycles with out_sum 1,2,3; len=0 behaves identically.
- ACC_BITS=IN_BITS=17, signed, len=2, sums 65535+1 -> out_sum=-65536 (0x10000), out_ovf=1; next frame 2+2 -> out_ovf=0.
- len=4; assert clear after 2 aligned samples, then send 4 fresh tags with sum=1 -> no output for the aborted frame; next out_sum=4, out_ovf=0.
- rst_n low mid-frame (count=2), then release and send len=2 frame 3,4 -> all outputs 0 during reset; out_sum=7 after release.
